rv_fetch_pc_unit: RTL
=====================

Name: rv_fetch_pc_unit

Overview:
- Program-counter and instruction-fetch stage of the single-cycle RISC-V core.
- Owns the PC register and issues instruction-memory requests over a req/ack handshake.
- Latches the returned instruction and presents Opcode/Funct3/Funct7 to the combinational main controller.
- Consumes the controller's PCSrc and the datapath's Imm/RS1 to compute and commit the next PC once per executed instruction.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction register value on reset and after halt (addi x0,x0,0).

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-low reset.
- PCSrc  input  2  next-PC select from controller: 0 PC+4, 1 PC+Imm, 2 RS1+Imm, 3 hold PC.
- Imm  input  32  sign-extended immediate from immediate generator.
- RS1  input  32  register-file read port 1 value.
- Stall  input  1  data-memory wait; extends the execute cycle.
- IMemReq  output  1  instruction fetch request.
- IMemAddr  output  32  fetch address (equals PC).
- IMemAck  input  1  instruction data valid this cycle.
- IMemRData  input  32  instruction word.
- Instr  output  32  latched instruction.
- Opcode  output  7  Instr[6:0].
- Funct3  output  3  Instr[14:12].
- Funct7  output  7  Instr[31:25].
- InstrValid  output  1  high during the execute cycle(s) of Instr.
- PC  output  32  current PC.
- PC_4  output  32  PC+4, combinational, for writeback.
- Halted  output  1  misaligned-target trap, sticky until reset.

Behaviour:
- Reset (rst=0, async) values:
  - PC=RESET_PC, Instr=NOP_INSTR.
  - InstrValid=0, IMemReq=0, Halted=0, state=S_IDLE.
- FSM states:
  - S_IDLE: one cycle after reset release, then go to S_FETCH.
  - S_FETCH: IMemReq=1, IMemAddr=PC, InstrValid=0. On IMemAck=1, Instr<=IMemRData and go to S_EXEC. Zero-wait ack is legal in the first FETCH cycle. With no ack, remain in S_FETCH indefinitely.
  - S_EXEC: IMemReq=0, InstrValid=1.
    - If Stall=1: remain in S_EXEC; PC and Instr unchanged.
    - If Stall=0: PC<=NextPC and go to S_FETCH.
    - If NextPC[1:0]!=0: go to S_HALT instead; PC unchanged.
  - S_HALT: Halted=1, InstrValid=0, IMemReq=0, Instr<=NOP_INSTR. Exits only via reset.
- NextPC (32-bit, modulo 2^32, overflow wraps silently):
  - PCSrc=0 → PC+4.
  - PCSrc=1 → PC+Imm.
  - PCSrc=2 → (RS1+Imm) & ~32'h1.
  - PCSrc=3 → PC. Re-fetches the same address, giving a spin loop.
- Timing and handshake rules:
  - Minimum 2 cycles per instruction (FETCH+EXEC) with zero-wait memory.
  - IMemAck outside S_FETCH is ignored; no state or Instr change.
  - Opcode/Funct3/Funct7 are combinational slices of Instr and are stable for the whole EXEC period.
  - IMemAddr holds PC in every state (only meaningful when IMemReq=1).
- Reset asserted mid-fetch or mid-stall aborts immediately. No pending request survives; the next fetch is at RESET_PC.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs CycleCnt[31:0] and RetireCnt[31:0], both reset to 0.
  - CycleCnt increments every clock not in S_HALT.
  - RetireCnt increments on each S_EXEC→S_FETCH transition (Stall=0, no trap).
  - Both wrap from 32'hFFFF_FFFF to 0.
- Not defined: ports are absent and no counter logic is synthesized.

Test Plan:
- Reset release, ack after 0 waits, PCSrc=0 for 3 instructions → IMemAddr sequence 0x00400000, 0x00400004, 0x00400008; InstrValid pulses 1 cycle each, 2 cycles apart.
- PC=0x00400010, PCSrc=1, Imm=-8 → next IMemAddr=0x00400008. PCSrc=2, RS1=0x00400101, Imm=4 → next IMemAddr=0x00400104 (bit0 cleared).
- Ack delayed 3 cycles, then Stall=1 for 2 EXEC cycles → IMemReq high 4 cycles; InstrValid high 3 cycles; PC advances once; Instr stable throughout.
- PCSrc=1, Imm=2 → Halted=1 next cycle; PC unchanged; IMemReq stays 0; Instr=0x00000013; spurious IMemAck ignored.
- rst pulled low during a stalled EXEC with PC=0x00400020 → PC=0x00400000 and InstrValid=0 immediately; first fetch 2 cycles after release.
- With FETCH_PERF_CNT_EN: 5 instructions at zero wait → RetireCnt=5, CycleCnt=11 (1 idle + 10) at the cycle after the 5th EXEC.

Source files
------------

// File: rtl/rv_fetch_pc_unit.sv
// rv_fetch_pc_unit: PC register and instruction-fetch stage of the single-cycle
// RISC-V core. Issues fetches over a req/ack handshake, latches the returned
// instruction, and commits the next PC once per executed instruction.
//
// Handshake: IMemReq is held high for the whole S_FETCH state with IMemAddr=PC;
// the fetch completes on the first rising edge at which IMemAck=1 is seen
// (an ack in the first fetch cycle is legal). IMemAck in any other state is
// ignored.
//
// Optional build macro FETCH_PERF_CNT_EN adds the CycleCnt/RetireCnt counters.
module rv_fetch_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0040_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  PCSrc,
   input  logic [31:0] Imm,
   input  logic [31:0] RS1,
   input  logic        Stall,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [31:0] IMemRData,
   output logic [31:0] Instr,
   output logic [6:0]  Opcode,
   output logic [2:0]  Funct3,
   output logic [6:0]  Funct7,
   output logic        InstrValid,
   output logic [31:0] PC,
   output logic [31:0] PC_4,
   output logic        Halted,
   output logic [1:0]  DbgState
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] CycleCnt,
   output logic [31:0] RetireCnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] next_pc;
   logic        misaligned;
   logic        retire;

   // Next-PC selection; all sums wrap modulo 2^32
   always_comb begin
      next_pc = pc_q + 32'd4;
      case (PCSrc)
         2'd0: next_pc = pc_q + 32'd4;
         2'd1: next_pc = pc_q + Imm;
         2'd2: next_pc = (RS1 + Imm) & ~32'h1;
         2'd3: next_pc = pc_q;
         default: next_pc = pc_q + 32'd4;
      endcase
   end

   assign misaligned = (next_pc[1:0] != 2'b00);
   // An instruction retires when EXEC ends without a stall or a trap
   assign retire     = (state_q == S_EXEC) && !Stall && !misaligned;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: if (IMemAck) state_d = S_EXEC;
         S_EXEC:  if (!Stall) state_d = misaligned ? S_HALT : S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from the current state
   always_comb begin
      IMemReq    = 1'b0;
      InstrValid = 1'b0;
      Halted     = 1'b0;
      case (state_q)
         S_FETCH: IMemReq    = 1'b1;
         S_EXEC:  InstrValid = 1'b1;
         S_HALT:  Halted     = 1'b1;
         default: ;
      endcase
   end

   // PC and instruction register next values; a trap clears Instr to NOP on entry
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      if (state_q == S_FETCH && IMemAck) begin
         instr_d = IMemRData;
      end
      if (retire) begin
         pc_d = next_pc;
      end
      if (state_d == S_HALT) begin
         instr_d = NOP_INSTR;
      end
   end

   // PC and instruction registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign IMemAddr = pc_q;
   assign PC       = pc_q;
   assign PC_4     = pc_q + 32'd4;
   assign Instr    = instr_q;
   assign Opcode   = instr_q[6:0];
   assign Funct3   = instr_q[14:12];
   assign Funct7   = instr_q[31:25];
   assign DbgState = state_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] cycle_cnt_q, cycle_cnt_d;
   logic [31:0] retire_cnt_q, retire_cnt_d;

   // Counter increments; both wrap naturally at 2^32
   always_comb begin
      cycle_cnt_d  = cycle_cnt_q;
      retire_cnt_d = retire_cnt_q;
      if (state_q != S_HALT) cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (retire)            retire_cnt_d = retire_cnt_q + 32'd1;
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt_q  <= 32'd0;
         retire_cnt_q <= 32'd0;
      end else begin
         cycle_cnt_q  <= cycle_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign CycleCnt  = cycle_cnt_q;
   assign RetireCnt = retire_cnt_q;
`endif

endmodule
